routine_selector: RTL and testbench
===================================

Name: routine_selector

Overview:
- Downstream output stage for the light routines.
- Takes the 46-bit output buses of four routines and selects one, using a debounced pushbutton to step through them.
- Drives each routine's run-enable, so the newly chosen routine restarts from its initial state.
- Registers the board-facing LED and seven-segment outputs, with a blanking interval between routines.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a key level change; legal range 1..2^24-1
BLANK_CYCLES, 5000000, cycles of blanked outputs after reset or a routine change; 0 is treated as 1; max 2^24-1

Ports:
Clock  input  1  system clock; all state on rising edge
Reset  input  1  synchronous, active-high reset
NextKey  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to Clock
Bus0  input  46  routine 0 output bus
Bus1  input  46  routine 1 output bus
Bus2  input  46  routine 2 output bus
Bus3  input  46  routine 3 output bus
RoutineEnable  output  4  one-hot run-enable, bit i drives routine i's Reset input; high = run
Select  output  2  index of the current routine
LedRed  output  10  red LEDs, active-high
LedGrn  output  8  green LEDs, active-high
Hex3  output  7  seven-segment digit 3, active-low segments
Hex2  output  7  seven-segment digit 2
Hex1  output  7  seven-segment digit 1
Hex0  output  7  seven-segment digit 0

Behaviour:
- Bus field map, identical for every BusN:
  - [45:36] LedRed
  - [35:28] LedGrn
  - [27:21] Hex3
  - [20:14] Hex2
  - [13:7] Hex1
  - [6:0] Hex0
- Synchroniser: two flops on NextKey; both reset to 1 (released).
- Debouncer:
  - Stable level register resets to 1; 24-bit counter resets to 0.
  - While the synchronised level equals the stable level, the counter clears to 0.
  - While it differs, the counter increments; when it reaches DEBOUNCE_CYCLES-1 with the level still differing, the stable level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press event: one-cycle internal pulse on a stable-level 1->0 transition only. Release generates no event. A key held indefinitely yields exactly one event.
- FSM states: BLANK, RUN.
- Reset values:
  - State BLANK, Select=0, blank counter=0, RoutineEnable=4'b0000.
  - LedRed=0, LedGrn=0, Hex3..Hex0=7'b1111111.
- BLANK state:
  - RoutineEnable=0000; LEDs 0; all Hex 7'b1111111.
  - Blank counter increments each cycle. When it equals max(BLANK_CYCLES,1)-1, the next state is RUN.
- RUN state:
  - RoutineEnable = one-hot of Select.
  - Outputs register the fields of Bus[Select]: input sampled at edge n appears on outputs after edge n.
  - Exactly one cycle of latency; no combinational path from any BusN to any output.
- Press in RUN: Select <= Select+1 (mod 4, so 3 wraps to 0); state <= BLANK; blank counter <= 0. Outputs blank starting on the next cycle.
- Press in BLANK: Select <= Select+1 (mod 4); blank counter restarts at 0; state stays BLANK.
- Press on the same cycle as blank expiry: the press wins, so state stays BLANK and the counter restarts.
- Reset mid-operation (debounce in progress, BLANK or RUN): returns to the reset values on the next edge and discards any partial debounce.
- Enable vs outputs: the first RUN cycle asserts RoutineEnable and outputs Bus[Select] registered from that cycle. The routine's own one-cycle reset state is therefore visible first.
- All outputs are registered; RoutineEnable and Select are registered.

Test Plan (DEBOUNCE_CYCLES=4, BLANK_CYCLES=3):
- Reset, then hold NextKey=1 and drive Bus0=46'h2AAA_AAAA_AAAA: outputs blank (Hex=7F, LEDs 0, enable 0000) for 3 cycles. Then RoutineEnable=0001, Select=0, LedRed=10'h2AA and Hex0=7'h2A one cycle after RUN entry.
- In RUN, pulse NextKey=0 for 3 cycles (glitch): no change to Select, state or outputs.
- In RUN, hold NextKey=0 for 20 cycles: exactly one event. Select 0->1, outputs blank for 3 cycles, then RoutineEnable=0010 and outputs track Bus1. Release produces no event.
- Four accepted presses from Select=0: Select walks 1,2,3,0; RoutineEnable ends at 0001.
- Second press accepted during BLANK: Select advances again and the blank counter restarts. RUN is entered exactly 3 cycles after the second press's event.
- Assert Reset for 1 cycle during RUN with Select=2: next cycle Select=0, enable 0000, outputs blank. RUN with enable 0001 follows 3 cycles after Reset deasserts.

Source files
------------

// File: rtl/routine_selector.sv
// Output stage for the light routines: picks one of four 46-bit routine buses
// with a debounced key, drives run-enables and registers the board outputs.
//
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   NextKey                 raw active-low pushbutton (async to Clock)
//   Bus0..Bus3              routine output buses {LedRed,LedGrn,Hex3..Hex0}
//   RoutineEnable           one-hot run-enable for the selected routine
//   Select                  index of the current routine
//   LedRed, LedGrn          active-high LEDs
//   Hex3..Hex0              active-low seven-segment digits
module routine_selector #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_CYCLES    = 5000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        NextKey,
  input  logic [45:0] Bus0,
  input  logic [45:0] Bus1,
  input  logic [45:0] Bus2,
  input  logic [45:0] Bus3,
  output logic [3:0]  RoutineEnable,
  output logic [1:0]  Select,
  output logic [9:0]  LedRed,
  output logic [7:0]  LedGrn,
  output logic [6:0]  Hex3,
  output logic [6:0]  Hex2,
  output logic [6:0]  Hex1,
  output logic [6:0]  Hex0
);

  localparam logic [23:0] DebLast =
    24'(DEBOUNCE_CYCLES - 1);

  // A zero blanking length behaves like one cycle.
  localparam logic [23:0] BlankLast =
    (BLANK_CYCLES < 2) ? 24'd0 : 24'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK,
    RUN
  } state_t;

  logic        key_s1;
  logic        key_s2;
  logic        stable;
  logic        stable_d;
  logic [23:0] deb_cnt;
  logic        press;

  state_t      state;
  state_t      state_n;
  logic [1:0]  sel;
  logic [1:0]  sel_n;
  logic [23:0] blank_cnt;
  logic [23:0] blank_cnt_n;
  logic [45:0] bus_sel;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      key_s1   <= NextKey;
      key_s2   <= key_s1;
      stable_d <= stable;
      if (key_s2 == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DebLast) begin
        stable  <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 24'd1;
      end
    end
  end

  // Falling edge of the debounced level only; release is ignored.
  assign press = stable_d & ~stable;

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    blank_cnt_n = blank_cnt;
    unique case (state)
      BLANK: begin
        if (press) begin
          sel_n       = sel + 2'd1;
          blank_cnt_n = '0;
        end else if (blank_cnt == BlankLast) begin
          state_n     = RUN;
          blank_cnt_n = '0;
        end else begin
          blank_cnt_n = blank_cnt + 24'd1;
        end
      end
      RUN: begin
        if (press) begin
          sel_n       = sel + 2'd1;
          state_n     = BLANK;
          blank_cnt_n = '0;
        end
      end
      default: state_n = BLANK;
    endcase
  end

  always_comb begin
    bus_sel = Bus0;
    unique case (sel)
      2'd0: bus_sel = Bus0;
      2'd1: bus_sel = Bus1;
      2'd2: bus_sel = Bus2;
      2'd3: bus_sel = Bus3;
      default: bus_sel = Bus0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= BLANK;
      sel           <= '0;
      blank_cnt     <= '0;
      RoutineEnable <= '0;
      LedRed        <= '0;
      LedGrn        <= '0;
      Hex3          <= '1;
      Hex2          <= '1;
      Hex1          <= '1;
      Hex0          <= '1;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      blank_cnt <= blank_cnt_n;
      if (state_n == RUN) begin
        RoutineEnable <= 4'b0001 << sel_n;
      end else begin
        RoutineEnable <= '0;
      end
      // Data is passed only while staying in RUN, so the first RUN
      // cycle still shows blank and a press blanks immediately.
      if (state == RUN && state_n == RUN) begin
        LedRed <= bus_sel[45:36];
        LedGrn <= bus_sel[35:28];
        Hex3   <= bus_sel[27:21];
        Hex2   <= bus_sel[20:14];
        Hex1   <= bus_sel[13:7];
        Hex0   <= bus_sel[6:0];
      end else begin
        LedRed <= '0;
        LedGrn <= '0;
        Hex3   <= '1;
        Hex2   <= '1;
        Hex1   <= '1;
        Hex0   <= '1;
      end
    end
  end

  assign Select = sel;

endmodule

// File: tb/tb_routine_selector.sv
// Bench for routine_selector: two instances with different timing parameters
// driven by the same stimulus and checked against a behavioural model.
module tb_routine_selector;

  localparam int D0 = 4;
  localparam int B0 = 3;
  localparam int D1 = 1;
  localparam int B1 = 10;
  localparam logic [45:0] BLANKV = 46'h0000FFFFFFF;
  localparam logic [45:0] PAT0 = 46'h2AAAAAAAAAAA;

  logic Clock;
  logic Reset;
  logic NextKey;
  logic [3:0][45:0] bus;

  logic [1:0][3:0] en;
  logic [1:0][1:0] sl;
  logic [1:0][9:0] lr;
  logic [1:0][7:0] lg;
  logic [1:0][6:0] h3;
  logic [1:0][6:0] h2;
  logic [1:0][6:0] h1;
  logic [1:0][6:0] h0;

  int checks = 0;
  int errors = 0;
  bit fix0;
  int runlen;

  routine_selector #(
    .DEBOUNCE_CYCLES(D0),
    .BLANK_CYCLES(B0)
  ) u_dut0 (
    .Clock(Clock), .Reset(Reset), .NextKey(NextKey),
    .Bus0(bus[0]), .Bus1(bus[1]), .Bus2(bus[2]), .Bus3(bus[3]),
    .RoutineEnable(en[0]), .Select(sl[0]),
    .LedRed(lr[0]), .LedGrn(lg[0]),
    .Hex3(h3[0]), .Hex2(h2[0]), .Hex1(h1[0]), .Hex0(h0[0])
  );

  routine_selector #(
    .DEBOUNCE_CYCLES(D1),
    .BLANK_CYCLES(B1)
  ) u_dut1 (
    .Clock(Clock), .Reset(Reset), .NextKey(NextKey),
    .Bus0(bus[0]), .Bus1(bus[1]), .Bus2(bus[2]), .Bus3(bus[3]),
    .RoutineEnable(en[1]), .Select(sl[1]),
    .LedRed(lr[1]), .LedGrn(lg[1]),
    .Hex3(h3[1]), .Hex2(h2[1]), .Hex1(h1[1]), .Hex0(h0[1])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [45:0] dat(int i);
    return {lr[i], lg[i], h3[i], h2[i], h1[i], h0[i]};
  endfunction

  function automatic logic [45:0] rbus();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[45:0];
  endfunction

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  // Behavioural model: keys reach the debouncer two samples late, a level is
  // accepted after DEB consecutive differing samples, a press acts one cycle
  // after acceptance, and each press (or reset) starts a blank window.
  int          mdeb [2];
  int          mbl  [2];
  bit          ms1  [2];
  bit          ms2  [2];
  bit          mst  [2];
  bit          mpend[2];
  bit          mact [2];
  bit          mval [2];
  int          mrun [2];
  int          mleft[2];
  logic [1:0]  msel [2];
  logic [3:0]  xen  [2];
  logic [45:0] xdat [2];

  initial begin
    mdeb[0] = D0;
    mdeb[1] = D1;
    mbl[0]  = (B0 < 1) ? 1 : B0;
    mbl[1]  = (B1 < 1) ? 1 : B1;
    mval[0] = 1'b0;
    mval[1] = 1'b0;
  end

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      bit k;
      bit pr;
      bit was;
      if (Reset) begin
        ms1[i]   = 1'b1;
        ms2[i]   = 1'b1;
        mst[i]   = 1'b1;
        mpend[i] = 1'b0;
        mrun[i]  = 0;
        msel[i]  = 2'd0;
        mleft[i] = mbl[i];
        mact[i]  = 1'b0;
        xen[i]   = 4'b0000;
        xdat[i]  = BLANKV;
        mval[i]  = 1'b1;
      end else if (mval[i]) begin
        k        = ms2[i];
        ms2[i]   = ms1[i];
        ms1[i]   = NextKey;
        pr       = mpend[i];
        mpend[i] = 1'b0;
        if (k != mst[i]) begin
          mrun[i]++;
          if (mrun[i] >= mdeb[i]) begin
            mst[i]  = k;
            mrun[i] = 0;
            if (!k) mpend[i] = 1'b1;
          end
        end else begin
          mrun[i] = 0;
        end
        was = mact[i];
        if (pr) begin
          msel[i]  = 2'((int'(msel[i]) + 1) % 4);
          mleft[i] = mbl[i];
        end else if (mleft[i] > 0) begin
          mleft[i]--;
        end
        mact[i] = (mleft[i] == 0);
        xen[i]  = mact[i] ? 4'(1 << msel[i]) : 4'b0000;
        xdat[i] = (mact[i] && was) ? bus[msel[i]] : BLANKV;
      end
    end
  end

  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (mval[i]) begin
        chk($sformatf("u%0d_enable", i), 64'(en[i]), 64'(xen[i]));
        chk($sformatf("u%0d_select", i), 64'(sl[i]), 64'(msel[i]));
        chk($sformatf("u%0d_outputs", i), 64'(dat(i)), 64'(xdat[i]));
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
    for (int j = 0; j < 4; j++) begin
      if (!(fix0 && j == 0)) bus[j] = rbus();
    end
  endtask

  task automatic tap(int low, int high);
    NextKey = 1'b0;
    repeat (low) step();
    NextKey = 1'b1;
    repeat (high) step();
  endtask

  initial begin
    fix0    = 1'b1;
    Reset   = 1'b1;
    NextKey = 1'b1;
    for (int j = 0; j < 4; j++) bus[j] = rbus();
    bus[0] = PAT0;

    step();
    Reset = 1'b0;
    chk("rst_outputs", 64'(dat(0)), 64'(BLANKV));
    chk("rst_enable", 64'(en[0]), 64'd0);
    chk("rst_select", 64'(sl[0]), 64'd0);
    step();
    step();
    chk("blank_enable", 64'(en[0]), 64'd0);
    chk("blank_hex0", 64'(h0[0]), 64'h7f);
    step();
    chk("run_enable", 64'(en[0]), 64'b0001);
    chk("run_first_blank", 64'(dat(0)), 64'(BLANKV));
    step();
    chk("run_ledred", 64'(lr[0]), 64'h2aa);
    chk("run_ledgrn", 64'(lg[0]), 64'haa);
    chk("run_hex3", 64'(h3[0]), 64'h55);
    chk("run_hex0", 64'(h0[0]), 64'h2a);

    tap(3, 10);
    chk("glitch_select", 64'(sl[0]), 64'd0);
    chk("glitch_enable", 64'(en[0]), 64'b0001);
    chk("glitch_ledred", 64'(lr[0]), 64'h2aa);

    tap(20, 12);
    chk("hold_select", 64'(sl[0]), 64'd1);
    chk("hold_enable", 64'(en[0]), 64'b0010);
    fix0 = 1'b0;

    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      tap(6, 14);
      chk("walk_select", 64'(sl[0]), 64'((k + 1) % 4));
    end
    chk("walk_enable", 64'(en[0]), 64'b0001);

    tap(2, 2);
    tap(2, 3);
    chk("blankpress_select", 64'(sl[1]), 64'd2);
    chk("blankpress_enable", 64'(en[1]), 64'd0);
    repeat (8) step();
    chk("blankpress_restart", 64'(en[1]), 64'd0);
    step();
    chk("blankpress_run", 64'(en[1]), 64'b0100);

    tap(6, 14);
    tap(6, 14);
    chk("pre_reset_enable", 64'(en[0]), 64'b0100);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_select", 64'(sl[0]), 64'd0);
    chk("midrst_enable", 64'(en[0]), 64'd0);
    chk("midrst_outputs", 64'(dat(0)), 64'(BLANKV));
    step();
    step();
    chk("midrst_blank", 64'(en[0]), 64'd0);
    step();
    chk("midrst_run", 64'(en[0]), 64'b0001);

    runlen = 0;
    for (int n = 0; n < 4000; n++) begin
      if (runlen == 0) begin
        NextKey = 1'($urandom_range(0, 1));
        runlen  = $urandom_range(1, 12);
      end
      runlen--;
      Reset = ($urandom_range(0, 299) == 0);
      step();
    end
    Reset   = 1'b0;
    NextKey = 1'b1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
